multiport_regfile: RTL and testbench

Parametrised integer register file for the pipelined core: NRD combinational read ports, NWR synchronous write ports, same-cycle write-to-read bypass, and a pending-write scoreboard that tells the issue stage which source registers still await a producer. After reset a sequential clear sweep zeroes every entry before `ready` is raised. Sits in ID, replacing the single-issue two-read/one-write register file, and feeds the hazard unit through `rd_busy`.

---
 rtl/multiport_regfile_pkg.sv | 14 +
 rtl/multiport_regfile_if.sv | 33 +++
 rtl/multiport_regfile_scoreboard.sv | 58 +++++
 rtl/multiport_regfile.sv | 107 ++++++++++
 tb/tb_multiport_regfile.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multiport_regfile_pkg.sv
// rtl/multiport_regfile_pkg.sv - shared defaults and state type for the multi-port register file
package multiport_regfile_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_SIZE       = 32;
  localparam int RF_NRD         = 2;
  localparam int RF_NWR         = 2;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } rf_state_e;

endpackage

// File: rtl/multiport_regfile_if.sv
// rtl/multiport_regfile_if.sv - read/write/issue bundle between ID stage and register file
interface multiport_regfile_if
  import multiport_regfile_pkg::*;
#(
  parameter int XLEN  = REG_DATA_WIDTH,
  parameter int NREGS = REG_SIZE,
  parameter int NRD   = RF_NRD,
  parameter int NWR   = RF_NWR
) ();
  localparam int AW = $clog2(NREGS);

  logic                ready;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;

  modport master (
    input  ready, rd_data, rd_busy,
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush
  );

endinterface

// File: rtl/multiport_regfile_scoreboard.sv
// rtl/multiport_regfile_scoreboard.sv - pending-producer bits per register and rd_busy generation
module regfile_scoreboard #(
  parameter int  NREGS  = 32,
  parameter int  NRD    = 2,
  parameter int  NWR    = 2,
  parameter bit  BYPASS = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_d;
  logic [AW-1:0]    ra;
  logic             hit;

  // wr_en arrives pre-qualified (ready and addr != 0); a new producer overrides a retiring one
  always_comb begin
    pending_d = flush ? '0 : pending;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) pending_d[wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (en) begin
      pending <= pending_d;
    end
  end

  always_comb begin
    rd_busy = '0;
    ra      = '0;
    hit     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra  = rd_addr[i*AW +: AW];
      hit = 1'b0;
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == ra)) hit = 1'b1;
      end
      rd_busy[i] = en && (ra != '0) && pending[ra] && !(BYPASS && hit);
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - NRD-read/NWR-write register file with bypass, clear sweep and scoreboard
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int XLEN   = REG_DATA_WIDTH,
  parameter int NREGS  = REG_SIZE,
  parameter int NRD    = RF_NRD,
  parameter int NWR    = RF_NWR,
  parameter bit BYPASS = 1'b1
) (
  input logic                clk,
  input logic                rst,
  multiport_regfile_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  rf_state_e           state_q;
  rf_state_e           state_d;
  logic [AW-1:0]       sweep_cnt;
  logic                ready;
  logic [NWR-1:0]      wr_act;
  logic [XLEN-1:0]     mem [NREGS];
  logic [NRD*XLEN-1:0] rd_data;
  logic [AW-1:0]       ra;
  logic [XLEN-1:0]     word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_cnt <= '0;
    end else if (state_q == ST_CLEAR) begin
      sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_CLEAR) && (sweep_cnt == AW'(NREGS - 1))) state_d = ST_READY;
  end

  assign ready = (state_q == ST_READY);

  always_comb begin
    wr_act = '0;
    for (int p = 0; p < NWR; p++) begin
      wr_act[p] = ready && bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != '0);
    end
  end

  // Later ports are applied last so the highest index wins on a shared address
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem[sweep_cnt] <= '0;
      end else begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_act[p]) mem[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    word    = '0;
    for (int i = 0; i < NRD; i++) begin
      ra   = bus.rd_addr[i*AW +: AW];
      word = mem[ra];
      if (BYPASS) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_act[p] && (bus.wr_addr[p*AW +: AW] == ra)) word = bus.wr_data[p*XLEN +: XLEN];
        end
      end
      if (ready && (ra != '0)) rd_data[i*XLEN +: XLEN] = word;
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.ready   = ready;

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .en        (ready),
    .wr_en     (wr_act),
    .wr_addr   (bus.wr_addr),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .flush     (bus.flush),
    .rd_addr   (bus.rd_addr),
    .rd_busy   (bus.rd_busy)
  );

endmodule

// File: tb/tb_multiport_regfile.sv
// tb/tb_multiport_regfile.sv - directed scoreboard bench running bypass and non-bypass instances side by side
module tb_multiport_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        flush = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiport_regfile_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) b1 ();
  multiport_regfile_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) b0 ();

  assign b1.rd_addr = rd_addr;   assign b0.rd_addr = rd_addr;
  assign b1.wr_en = wr_en;       assign b0.wr_en = wr_en;
  assign b1.wr_addr = wr_addr;   assign b0.wr_addr = wr_addr;
  assign b1.wr_data = wr_data;   assign b0.wr_data = wr_data;
  assign b1.iss_valid = iss_valid; assign b0.iss_valid = iss_valid;
  assign b1.iss_rd = iss_rd;     assign b0.iss_rd = iss_rd;
  assign b1.flush = flush;       assign b0.flush = flush;

  multiport_regfile #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .bus(b1)
  );
  multiport_regfile #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst(rst), .bus(b0)
  );

  typedef struct {
    int          kind;
    int          dut;
    int          port;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] observe(int kind, int dut, int port);
    logic [31:0] v;
    v = '0;
    case (kind)
      0: v = (dut == 1) ? b1.rd_data[port*32 +: 32] : b0.rd_data[port*32 +: 32];
      1: v = {31'b0, (dut == 1) ? b1.rd_busy[port] : b0.rd_busy[port]};
      default: v = {31'b0, (dut == 1) ? b1.ready : b0.ready};
    endcase
    return v;
  endfunction

  task automatic push(string tag, int kind, int dut, int port, logic [31:0] exp);
    exp_t e;
    e.kind = kind; e.dut = dut; e.port = port; e.exp = exp; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind, e.dut, e.port);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s byp=%0d port=%0d observed=%h expected=%h", e.tag, e.dut, e.port, obs, e.exp);
      end
    end
  endtask

  task automatic exp_rd(string tag, int port, logic [31:0] e_byp, logic [31:0] e_nobyp);
    push(tag, 0, 1, port, e_byp);
    push(tag, 0, 0, port, e_nobyp);
  endtask

  task automatic exp_busy(string tag, int port, logic b_byp, logic b_nobyp);
    push(tag, 1, 1, port, {31'b0, b_byp});
    push(tag, 1, 0, port, {31'b0, b_nobyp});
  endtask

  task automatic exp_ready(string tag, logic r);
    push(tag, 2, 1, 0, {31'b0, r});
    push(tag, 2, 0, 0, {31'b0, r});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    wr_en = '0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic rd(logic [4:0] a0, logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic issue(logic [4:0] a);
    iss_valid = 1'b1;
    iss_rd = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b1; idle(); rd(5'd5, 5'd0);
    repeat (3) tick();
    settle();
    exp_ready("reset_ready", 1'b0);
    exp_rd("reset_rd0", 0, 32'h0, 32'h0);
    exp_rd("reset_rd1", 1, 32'h0, 32'h0);
    exp_busy("reset_busy", 0, 1'b0, 1'b0);
    drain();

    // sweep: ready low for 32 cycles, writes and issues ignored
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      wr(0, 5'd5, 32'h0000FFFF); issue(5'd5);
      exp_ready("sweep_ready", 1'b0);
      exp_rd("sweep_rd", 0, 32'h0, 32'h0);
      drain();
      tick();
    end
    idle(); settle();
    exp_ready("sweep_done", 1'b1);
    exp_rd("sweep_x5", 0, 32'h0, 32'h0);
    exp_busy("sweep_busy_x5", 0, 1'b0, 1'b0);
    drain();

    // write x5 then read on both ports
    rd(5'd5, 5'd5); wr(0, 5'd5, 32'hDEADBEEF); settle();
    exp_rd("x5_same_cycle", 0, 32'hDEADBEEF, 32'h0);
    drain();
    tick(); idle(); settle();
    exp_rd("x5_p0", 0, 32'hDEADBEEF, 32'hDEADBEEF);
    exp_rd("x5_p1", 1, 32'hDEADBEEF, 32'hDEADBEEF);
    drain();

    // x0 is hardwired
    rd(5'd0, 5'd0); wr(1, 5'd0, 32'h1234); settle();
    exp_rd("x0_same_cycle", 0, 32'h0, 32'h0);
    drain();
    tick(); idle(); settle();
    exp_rd("x0_after", 1, 32'h0, 32'h0);
    drain();

    // bypass visibility
    rd(5'd7, 5'd5); wr(0, 5'd7, 32'hA5A5A5A5); settle();
    exp_rd("x7_bypass", 0, 32'hA5A5A5A5, 32'h0);
    exp_rd("x5_other_port", 1, 32'hDEADBEEF, 32'hDEADBEEF);
    drain();
    tick(); idle(); settle();
    exp_rd("x7_next", 0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    drain();

    // two ports on one address: highest port wins
    rd(5'd9, 5'd7); wr(0, 5'd9, 32'h11); wr(1, 5'd9, 32'h22); settle();
    exp_rd("x9_bypass_prio", 0, 32'h22, 32'h0);
    drain();
    tick(); idle(); settle();
    exp_rd("x9_prio", 0, 32'h22, 32'h22);
    exp_rd("x7_kept", 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    drain();

    // scoreboard: issue, retire, set-over-clear, flush
    rd(5'd3, 5'd4); issue(5'd3); settle();
    exp_busy("x3_before_issue", 0, 1'b0, 1'b0);
    drain();
    tick(); idle(); settle();
    exp_busy("x3_issued", 0, 1'b1, 1'b1);
    exp_busy("x4_idle", 1, 1'b0, 1'b0);
    drain();
    wr(0, 5'd3, 32'h33); settle();
    exp_busy("x3_retire_same", 0, 1'b0, 1'b1);
    drain();
    tick(); idle(); settle();
    exp_busy("x3_retired", 0, 1'b0, 1'b0);
    exp_rd("x3_value", 0, 32'h33, 32'h33);
    drain();
    wr(1, 5'd3, 32'h44); issue(5'd3); tick(); idle(); settle();
    exp_busy("x3_set_wins", 0, 1'b1, 1'b1);
    drain();
    issue(5'd8); tick(); idle(); rd(5'd3, 5'd8); flush = 1'b1; settle();
    exp_busy("x8_before_flush", 1, 1'b1, 1'b1);
    drain();
    tick(); idle(); settle();
    exp_busy("x3_flushed", 0, 1'b0, 1'b0);
    exp_busy("x8_flushed", 1, 1'b0, 1'b0);
    drain();
    issue(5'd3); tick(); idle(); flush = 1'b1; issue(5'd10); rd(5'd3, 5'd10); tick(); idle(); settle();
    exp_busy("x3_flush_issue", 0, 1'b0, 1'b0);
    exp_busy("x10_flush_issue", 1, 1'b1, 1'b1);
    drain();
    issue(5'd0); rd(5'd0, 5'd10); tick(); idle(); settle();
    exp_busy("x0_never_busy", 0, 1'b0, 1'b0);
    drain();

    // reset mid-sweep restarts the sweep
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_ready("mid_sweep_ready", 1'b0);
      drain();
      tick();
    end
    rst = 1'b1; tick(); settle();
    exp_ready("mid_rst_ready", 1'b0);
    drain();
    rst = 1'b0; rd(5'd5, 5'd9);
    for (int k = 0; k < 32; k++) begin
      exp_ready("restart_ready", 1'b0);
      drain();
      tick();
    end
    settle();
    exp_ready("restart_done", 1'b1);
    exp_rd("restart_x5", 0, 32'h0, 32'h0);
    exp_rd("restart_x9", 1, 32'h0, 32'h0);
    drain();

    // reset in READY with x3 pending
    rd(5'd3, 5'd3); issue(5'd3); tick(); idle(); wr(0, 5'd3, 32'h77); tick(); idle(); issue(5'd3); tick(); idle(); settle();
    exp_busy("x3_pending", 0, 1'b1, 1'b1);
    exp_rd("x3_pre_rst", 0, 32'h77, 32'h77);
    drain();
    rst = 1'b1; tick(); settle();
    exp_ready("ready_rst_drop", 1'b0);
    exp_busy("ready_rst_busy", 0, 1'b0, 1'b0);
    drain();
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      exp_ready("ready_rst_sweep", 1'b0);
      drain();
      tick();
    end
    settle();
    exp_ready("ready_rst_done", 1'b1);
    exp_rd("ready_rst_x3", 0, 32'h0, 32'h0);
    exp_busy("ready_rst_x3_busy", 0, 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
